// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, arbitrates IMEM between boot loader and fetch path.
// Optional issued-instruction counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer #(
    parameter int          IMEM_DEPTH = 128,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic [31:0]   imem_addr,
    output logic          imem_we,
    output logic [31:0]   imem_wdata,
    input  logic [31:0]   imem_rdata,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   ir,
    output logic [31:0]   ir_pc,
    output logic          ir_valid,
    output logic          halted,
    output logic          fault,
    output logic [31:0]   fetch_count
);

    localparam logic [31:0] PC_MASK = 32'(4 * IMEM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] ir_r, ir_s;
    logic [31:0] ir_pc_r, ir_pc_s;
    logic        ir_valid_r, ir_valid_s;
    logic        fault_r, fault_s;

    // State and fetch-pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_LOAD;
            pc_r       <= RESET_PC;
            ir_r       <= 32'h0000_0000;
            ir_pc_r    <= 32'h0000_0000;
            ir_valid_r <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            ir_r       <= ir_s;
            ir_pc_r    <= ir_pc_s;
            ir_valid_r <= ir_valid_s;
            fault_r    <= fault_s;
        end
    end

    // Next-state logic: redirect outranks stall, stall outranks halt detection.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        ir_s       = ir_r;
        ir_pc_s    = ir_pc_r;
        ir_valid_s = ir_valid_r;
        fault_s    = fault_r;
        case (state_r)
            ST_LOAD, ST_HALT: begin
                ir_valid_s = 1'b0;
                if (start) begin
                    state_s = ST_RUN;
                    pc_s    = RESET_PC;
                    fault_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    ir_valid_s = 1'b0;
                    // Targets outside the memory or off word alignment are fatal.
                    if ((redirect_pc[1:0] != 2'b00) || (redirect_pc > PC_MASK)) begin
                        fault_s = 1'b1;
                        state_s = ST_HALT;
                    end else begin
                        pc_s = redirect_pc;
                    end
                end else if (stall) begin
                    ir_valid_s = ir_valid_r;
                end else if (imem_rdata == HALT_WORD) begin
                    ir_valid_s = 1'b0;
                    state_s    = ST_HALT;
                end else begin
                    ir_s       = imem_rdata;
                    ir_pc_s    = pc_r;
                    ir_valid_s = 1'b1;
                    pc_s       = (pc_r + 32'd4) & PC_MASK;
                end
            end
            default: begin
                state_s    = ST_LOAD;
                ir_valid_s = 1'b0;
            end
        endcase
    end

    // Memory port mux: loader owns it outside RUN, fetch path inside RUN.
    always_comb begin
        ld_ready   = 1'b1;
        imem_we    = 1'b0;
        imem_addr  = 32'h0000_0000;
        imem_wdata = 32'h0000_0000;
        if (state_r == ST_RUN) begin
            ld_ready  = 1'b0;
            imem_addr = {{(32-AW){1'b0}}, pc_r[AW+1:2]};
        end else begin
            ld_ready   = 1'b1;
            imem_we    = ld_valid;
            imem_addr  = {{(32-AW){1'b0}}, ld_addr};
            imem_wdata = ld_data;
        end
    end

    assign ir       = ir_r;
    assign ir_pc    = ir_pc_r;
    assign ir_valid = ir_valid_r;
    assign halted   = (state_r == ST_HALT);
    assign fault    = fault_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_r;

    // Counts instructions consumed by decode; cleared when a run is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_r <= 32'h0000_0000;
        end else if (start && (state_r != ST_RUN)) begin
            fetch_count_r <= 32'h0000_0000;
        end else if (ir_valid_r && !stall) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign fetch_count = fetch_count_r;
`else
    assign fetch_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural program-counter model.
module tb_fetch_sequencer;

    localparam logic [31:0] HW = 32'hFFFF_FFFF;
    localparam logic [31:0] WA = 32'h0062_0820;
    localparam logic [31:0] WB = 32'h0145_4822;
    localparam logic [31:0] WC = 32'h2222_2222;
    localparam logic [31:0] WD = 32'h3333_3333;
    localparam logic [31:0] WE = 32'h4444_4444;

    logic        clk, rst_n, start, ld_valid, ld_ready, imem_we, stall, redirect;
    logic [6:0]  ld_addr;
    logic [31:0] ld_data, imem_addr, imem_wdata, imem_rdata, redirect_pc;
    logic [31:0] ir, ir_pc, fetch_count;
    logic        ir_valid, halted, fault;

    logic [31:0] mem     [128];
    logic [31:0] ref_mem [128];

    logic        m_run, m_halt, m_fault, m_irv;
    logic [31:0] m_pc, m_ir, m_irpc, m_cnt;

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted), .fault(fault),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: written by the DUT, read combinationally.
    assign imem_rdata = mem[imem_addr[6:0]];
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr[6:0]] <= imem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_halt = 1'b0; m_fault = 1'b0; m_irv = 1'b0;
        m_pc = 32'h0; m_ir = 32'h0; m_irpc = 32'h0; m_cnt = 32'h0;
    endtask

    task automatic idle_inputs();
        start = 1'b0; ld_valid = 1'b0; ld_addr = 7'd0; ld_data = 32'h0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    endtask

    // One clock: check combinational port mux, advance model, check registered outputs.
    task automatic cycle();
        logic [31:0] w;
        logic was_run, consumed;
        #2;
        chk1("ld_ready", ld_ready, !m_run);
        chk1("imem_we", imem_we, !m_run && ld_valid);
        chk("imem_addr", imem_addr, m_run ? (m_pc / 32'd4) : {25'd0, ld_addr});
        if (!m_run) chk("imem_wdata", imem_wdata, ld_data);
        was_run  = m_run;
        consumed = m_irv && !stall;
        if (!m_run) begin
            if (ld_valid) ref_mem[ld_addr] = ld_data;
            if (start) begin
                m_run = 1'b1; m_halt = 1'b0; m_pc = 32'h0; m_fault = 1'b0;
            end
        end else if (redirect) begin
            m_irv = 1'b0;
            if ((redirect_pc % 32'd4 != 32'd0) || (redirect_pc >= 32'd512)) begin
                m_fault = 1'b1; m_run = 1'b0; m_halt = 1'b1;
            end else begin
                m_pc = redirect_pc;
            end
        end else if (!stall) begin
            w = ref_mem[7'(m_pc / 32'd4)];
            if (w == HW) begin
                m_irv = 1'b0; m_run = 1'b0; m_halt = 1'b1;
            end else begin
                m_ir = w; m_irpc = m_pc; m_irv = 1'b1; m_pc = (m_pc + 32'd4) % 32'd512;
            end
        end
`ifdef FETCH_PERF_CNT_EN
        if (!was_run && start) m_cnt = 32'h0;
        else if (consumed) m_cnt = m_cnt + 32'd1;
`else
        if (was_run && consumed) m_cnt = 32'h0;
`endif
        @(posedge clk);
        #1;
        chk1("ir_valid", ir_valid, m_irv);
        chk("ir", ir, m_ir);
        chk("ir_pc", ir_pc, m_irpc);
        chk1("halted", halted, m_halt);
        chk1("fault", fault, m_fault);
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        idle_inputs();
        #3;
        rst_n = 1'b0;
        #1;
        chk1("rst_ir_valid", ir_valid, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_ld_ready", ld_ready, 1'b1);
        chk1("rst_fault", fault, 1'b0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_pc", ir_pc, 32'h0);
        chk("rst_fetch_count", fetch_count, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        start, ld_valid;
        logic [6:0]  ld_addr;
        logic [31:0] ld_data;
        logic        stall, redirect;
        logic [31:0] rpc;
        logic        e_irv;
        logic [31:0] e_ir, e_irpc;
        logic        e_halt, e_fault;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic st, input logic lv, input logic [6:0] la,
                                input logic [31:0] ld, input logic sl, input logic rd,
                                input logic [31:0] rp, input logic ev, input logic [31:0] ei,
                                input logic [31:0] ep, input logic eh, input logic ef);
        vec_t v;
        v.start = st; v.ld_valid = lv; v.ld_addr = la; v.ld_data = ld;
        v.stall = sl; v.redirect = rd; v.rpc = rp;
        v.e_irv = ev; v.e_ir = ei; v.e_irpc = ep; v.e_halt = eh; v.e_fault = ef;
        return v;
    endfunction

    initial begin
        logic [31:0] prev_pc;
        logic        wrap_seen;
        int          tmp;

        for (int i = 0; i < 128; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk1("reset_ir_valid", ir_valid, 1'b0);
        chk1("reset_halted", halted, 1'b0);
        chk1("reset_fault", fault, 1'b0);
        chk1("reset_ld_ready", ld_ready, 1'b1);
        chk("reset_ir", ir, 32'h0);
        chk("reset_fetch_count", fetch_count, 32'h0);

        //            st   lv   addr  data          sl   rd   rpc     irv  ir  ir_pc   halt fault
        tbl[0]  = mk(1'b0,1'b1,7'd0,WA,          1'b0,1'b0,32'h0,  1'b0,32'h0,32'h0, 1'b0,1'b0);
        tbl[1]  = mk(1'b0,1'b1,7'd1,WB,          1'b0,1'b0,32'h0,  1'b0,32'h0,32'h0, 1'b0,1'b0);
        tbl[2]  = mk(1'b0,1'b1,7'd2,HW,          1'b0,1'b0,32'h0,  1'b0,32'h0,32'h0, 1'b0,1'b0);
        tbl[3]  = mk(1'b1,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b0,32'h0,32'h0, 1'b0,1'b0);
        tbl[4]  = mk(1'b0,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b1,WA,32'h0,    1'b0,1'b0);
        tbl[5]  = mk(1'b0,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b1,WB,32'h4,    1'b0,1'b0);
        tbl[6]  = mk(1'b0,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b0,WB,32'h4,    1'b1,1'b0);
        tbl[7]  = mk(1'b0,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b0,WB,32'h4,    1'b1,1'b0);
        tbl[8]  = mk(1'b0,1'b1,7'd2,WC,          1'b0,1'b0,32'h0,  1'b0,WB,32'h4,    1'b1,1'b0);
        tbl[9]  = mk(1'b0,1'b1,7'd3,WD,          1'b0,1'b0,32'h0,  1'b0,WB,32'h4,    1'b1,1'b0);
        tbl[10] = mk(1'b0,1'b1,7'd4,WE,          1'b0,1'b0,32'h0,  1'b0,WB,32'h4,    1'b1,1'b0);
        tbl[11] = mk(1'b0,1'b1,7'd5,HW,          1'b0,1'b0,32'h0,  1'b0,WB,32'h4,    1'b1,1'b0);
        tbl[12] = mk(1'b1,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b0,WB,32'h4,    1'b0,1'b0);
        tbl[13] = mk(1'b0,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b1,WA,32'h0,    1'b0,1'b0);
        tbl[14] = mk(1'b0,1'b1,7'd0,32'hDEADBEEF,1'b0,1'b0,32'h0,  1'b1,WB,32'h4,    1'b0,1'b0);
        tbl[15] = mk(1'b0,1'b0,7'd0,32'h0,       1'b1,1'b0,32'h0,  1'b1,WB,32'h4,    1'b0,1'b0);
        tbl[16] = mk(1'b0,1'b0,7'd0,32'h0,       1'b1,1'b0,32'h0,  1'b1,WB,32'h4,    1'b0,1'b0);
        tbl[17] = mk(1'b0,1'b0,7'd0,32'h0,       1'b1,1'b0,32'h0,  1'b1,WB,32'h4,    1'b0,1'b0);
        tbl[18] = mk(1'b0,1'b0,7'd0,32'h0,       1'b1,1'b1,32'h10, 1'b0,WB,32'h4,    1'b0,1'b0);
        tbl[19] = mk(1'b0,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b1,WE,32'h10,   1'b0,1'b0);
        tbl[20] = mk(1'b0,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b0,WE,32'h10,   1'b1,1'b0);
        tbl[21] = mk(1'b1,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b0,WE,32'h10,   1'b0,1'b0);
        tbl[22] = mk(1'b0,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b1,WA,32'h0,    1'b0,1'b0);
        tbl[23] = mk(1'b0,1'b0,7'd0,32'h0,       1'b0,1'b1,32'h6,  1'b0,WA,32'h0,    1'b1,1'b1);
        tbl[24] = mk(1'b0,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b0,WA,32'h0,    1'b1,1'b1);
        tbl[25] = mk(1'b1,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b0,WA,32'h0,    1'b0,1'b0);
        tbl[26] = mk(1'b0,1'b0,7'd0,32'h0,       1'b0,1'b0,32'h0,  1'b1,WA,32'h0,    1'b0,1'b0);

        for (int i = 0; i < 27; i++) begin
            start = tbl[i].start; ld_valid = tbl[i].ld_valid; ld_addr = tbl[i].ld_addr;
            ld_data = tbl[i].ld_data; stall = tbl[i].stall; redirect = tbl[i].redirect;
            redirect_pc = tbl[i].rpc;
            cycle();
            chk1($sformatf("vec%0d_ir_valid", i), ir_valid, tbl[i].e_irv);
            chk($sformatf("vec%0d_ir", i), ir, tbl[i].e_ir);
            chk($sformatf("vec%0d_ir_pc", i), ir_pc, tbl[i].e_irpc);
            chk1($sformatf("vec%0d_halted", i), halted, tbl[i].e_halt);
            chk1($sformatf("vec%0d_fault", i), fault, tbl[i].e_fault);
        end

        // PC wrap: fill every word with non-halt code and run past the last address.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            idle_inputs();
            ld_valid = 1'b1; ld_addr = 7'(i); ld_data = 32'h5A00_0000 | 32'(i);
            cycle();
        end
        idle_inputs(); start = 1'b1; cycle();
        start = 1'b0;
        wrap_seen = 1'b0;
        prev_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 132; i++) begin
            cycle();
            if (prev_pc == 32'h1FC) begin
                chk("wrap_ir_pc", ir_pc, 32'h0);
                chk("wrap_ir", ir, 32'h5A00_0000);
                wrap_seen = 1'b1;
            end
            prev_pc = ir_pc;
        end
        chk1("wrap_reached", wrap_seen, 1'b1);

        // Reset mid-RUN leaves memory intact.
        do_reset();
        start = 1'b1; cycle();
        start = 1'b0; cycle();
        chk("post_reset_ir", ir, 32'h5A00_0000);
        chk("post_reset_ir_pc", ir_pc, 32'h0);
        cycle();
        chk("post_reset_ir2", ir, 32'h5A00_0001);

        // Randomized traffic against the model.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 24; i++) begin
                idle_inputs();
                ld_valid = 1'b1;
                ld_addr  = 7'($urandom_range(0, 127));
                ld_data  = ($urandom_range(0, 7) == 0) ? HW : $urandom;
                stall    = ($urandom_range(0, 1) == 0);
                cycle();
            end
            idle_inputs(); start = 1'b1; cycle();
            for (int i = 0; i < 60; i++) begin
                start    = ($urandom_range(0, 15) == 0);
                ld_valid = ($urandom_range(0, 3) == 0);
                ld_addr  = 7'($urandom_range(0, 127));
                ld_data  = $urandom;
                stall    = ($urandom_range(0, 3) == 0);
                redirect = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 3) != 0) begin
                    tmp = $urandom_range(0, 127);
                    redirect_pc = 32'(tmp) * 32'd4;
                end else begin
                    redirect_pc = $urandom;
                end
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
